// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port instruction-ROM arbiter.
// Optional feature in rom_arbiter: ROM_ARB_ALIGN_CHK_EN (misaligned-address check).
package rom_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LD = 1'b1;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Two-way round-robin tie-break: the port not served last wins a tie,
// and a lone requester always wins.
module rr_pick2
    import rom_arb_pkg::*;
(
    input  logic       req_if,
    input  logic       req_ld,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_if && (!req_ld || last == PORT_LD)) begin
            grant[PORT_IF] = 1'b1;
        end else if (req_ld) begin
            grant[PORT_LD] = 1'b1;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Fetch/load arbiter in front of a combinational instruction ROM.
// Define ROM_ARB_ALIGN_CHK_EN to zero-fill and flag misaligned reads.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              addr_err
);

    state_t            state, state_nx;
    logic              owner, owner_nx;
    logic              last, last_nx;
    logic [ADDR_W-1:0] rom_addr_nx;
    logic [DATA_W-1:0] if_data_nx, ld_data_nx, rd_word;
    logic              if_ack_nx, ld_ack_nx, addr_err_nx;
    logic              own_req, misalign;
    logic [1:0]        grant;

    rr_pick2 u_pick (
        .req_if (if_req),
        .req_ld (ld_req),
        .last   (last),
        .grant  (grant)
    );

    assign own_req = (owner == PORT_IF) ? if_req : ld_req;

`ifdef ROM_ARB_ALIGN_CHK_EN
    assign misalign = |rom_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign rd_word = misalign ? '0 : rom_data;
    assign busy    = (state == RD);

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        last_nx     = last;
        rom_addr_nx = rom_addr;
        if_data_nx  = if_data;
        ld_data_nx  = ld_data;
        if_ack_nx   = 1'b0;
        ld_ack_nx   = 1'b0;
        addr_err_nx = 1'b0;
        unique case (state)
            IDLE: begin
                if (|grant) begin
                    owner_nx    = grant[PORT_LD];
                    last_nx     = grant[PORT_LD];
                    rom_addr_nx = grant[PORT_LD] ? ld_addr : if_addr;
                    state_nx    = RD;
                end
            end
            RD: begin
                state_nx = IDLE;
                // An owner that gave up its request gets neither ack nor data.
                if (own_req) begin
                    addr_err_nx = misalign;
                    if (owner == PORT_IF) begin
                        if_data_nx = rd_word;
                        if_ack_nx  = 1'b1;
                    end else begin
                        ld_data_nx = rd_word;
                        ld_ack_nx  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= PORT_IF;
            last     <= PORT_LD;
            rom_addr <= '0;
            if_data  <= '0;
            ld_data  <= '0;
            if_ack   <= 1'b0;
            ld_ack   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            last     <= last_nx;
            rom_addr <= rom_addr_nx;
            if_data  <= if_data_nx;
            ld_data  <= ld_data_nx;
            if_ack   <= if_ack_nx;
            ld_ack   <= ld_ack_nx;
            addr_err <= addr_err_nx;
        end
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width of the instruction ROM.
REQ-002 Parameter DATA_W, default 32, ROM word width.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  fetch-port request; held high with if_addr stable until if_ack.
REQ-006 if_addr  input  ADDR_W  fetch byte address.
REQ-007 if_ack  output  1  one-cycle pulse: if_data is valid.
REQ-008 if_data  output  DATA_W  registered fetch result; holds until the next if_ack.
REQ-009 ld_req, ld_addr, ld_ack, ld_data  (same directions and widths as if_*)  load-port handshake for constant reads from ROM.
REQ-010 rom_addr  output  ADDR_W  registered address to the combinational ROM.
REQ-011 rom_data  input  DATA_W  ROM read data, combinational from rom_addr.
REQ-012 busy  output  1  high while a read is in flight (state RD).
REQ-013 addr_err  output  1  one-cycle pulse on a misaligned access (see Configuration).

Function
REQ-014 The FSM SHALL have two states: IDLE and RD.
REQ-015 IDLE: if either req is high, the block SHALL grant one port, latch its address into rom_addr, record the owner and go to RD on the same edge.
REQ-016 Both requests high in IDLE: the port not served last SHALL win (2-way round-robin); a single requester always wins.
REQ-017 RD: on the next edge, rom_data SHALL be captured into the owner's data register, the owner's ack SHALL pulse for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-018 Latency: req sampled high at edge N -> ack high during the cycle following edge N+1; throughput is one read per two cycles.
REQ-019 The non-owner's ack and data register SHALL be unaffected by a read it does not own.
REQ-020 If the owner deasserts req while in RD, ack SHALL be suppressed and its data register SHALL not update; the FSM still returns to IDLE and the last-served pointer still updates.
REQ-021 rom_addr SHALL hold its value in IDLE; only a grant changes it.
REQ-022 if_ack and ld_ack SHALL never be high in the same cycle.

Reset
REQ-023 On rst: state=IDLE, rom_addr=0, if_data=0, ld_data=0, if_ack=0, ld_ack=0, addr_err=0, busy=0; the last-served pointer SHALL be set to "load" so fetch wins the first tie.
REQ-024 rst asserted during RD SHALL abort the read with no ack; requesters keep req high and are re-served after rst falls.

Configuration
REQ-025 Macro ROM_ARB_ALIGN_CHK_EN. Defined: a grant whose address has [1:0]!=0 SHALL still go to RD, but the RD completion SHALL load 0 into the owner's data register, pulse the owner's ack, and pulse addr_err in the same cycle. Undefined: addr[1:0] is ignored (the ROM decodes word address from [9:2]) and addr_err SHALL be tied 0.

Structure
REQ-026 A shared package rom_arb_pkg SHALL hold the state encoding (IDLE, RD), port-ID constants (PORT_IF=0, PORT_LD=1) and default ADDR_W/DATA_W.
REQ-027 The tie-break SHALL be in one sub-module, rr_pick2 (inputs: two requests, last-served; outputs: grant one-hot).

Verification
REQ-028 Reset, then if_req=1, if_addr=0x014 -> rom_addr=0x014 after one edge, if_ack pulses one cycle later with if_data=0x00408010; ld_ack stays 0.
REQ-029 if_req and ld_req both high from reset, if_addr=0x000, ld_addr=0x014 -> grants alternate IF, LD, IF, LD; if_data=0x00000000, ld_data=0x00408010; acks never overlap.
REQ-030 ld_req dropped in the RD cycle of its grant -> no ld_ack, ld_data keeps its previous value, next tie goes to IF.
REQ-031 rst raised during RD of a fetch to 0x014 -> no if_ack, all outputs 0 next cycle; with if_req still high after rst falls, fetch completes with 0x00408010.
REQ-032 With ROM_ARB_ALIGN_CHK_EN defined, ld_addr=0x015 -> ld_ack and addr_err pulse together, ld_data=0; without the macro, same stimulus -> ld_data=0x00408010, addr_err=0.
